// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter (master side) and the I/D-cache miss
// handlers plus the unified pipelined memory (slave side).
interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int WORDS  = 8
);
   localparam int WIDX_W = $clog2(WORDS);

   logic              i_miss;
   logic [ADDR_W-1:0] i_miss_addr;
   logic              d_miss;
   logic [ADDR_W-1:0] d_miss_addr;
   logic              d_wr;
   logic [ADDR_W-1:0] d_wr_addr;
   logic [DATA_W-1:0] d_wr_data;
   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_valid;
   logic              fill_valid;
   logic [DATA_W-1:0] fill_data;
   logic [WIDX_W-1:0] fill_word;
   logic              fill_to_d;
   logic              i_done;
   logic              d_done;
   logic              wr_ack;
   logic              busy;

   modport master (
      input  i_miss, i_miss_addr, d_miss, d_miss_addr,
      input  d_wr, d_wr_addr, d_wr_data,
      input  mem_rdata, mem_valid,
      output mem_en, mem_wr, mem_addr, mem_wdata,
      output fill_valid, fill_data, fill_word, fill_to_d,
      output i_done, d_done, wr_ack, busy
   );

   modport slave (
      output i_miss, i_miss_addr, d_miss, d_miss_addr,
      output d_wr, d_wr_addr, d_wr_data,
      output mem_rdata, mem_valid,
      input  mem_en, mem_wr, mem_addr, mem_wdata,
      input  fill_valid, fill_data, fill_word, fill_to_d,
      input  i_done, d_done, wr_ack, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Memory arbiter / cache-fill sequencer: write-through stores first, then
// block fills for the I- and D-cache, alternating on simultaneous misses.
module mem_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int WORDS   = 8,
   parameter int MEM_LAT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.master bus
);
   localparam int WIDX_W = $clog2(WORDS);
   localparam int CNT_W  = WIDX_W + 1;
   localparam logic [ADDR_W-1:0] BLK_MASK  = ~ADDR_W'(2 * WORDS - 1);
   localparam logic [CNT_W-1:0]  CNT_WORDS = CNT_W'(WORDS);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORDS - 1);

   if (MEM_LAT < 1 || WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : g_bad_params
      $error("mem_arbiter: WORDS must be a power of 2 >= 2 and MEM_LAT >= 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FILL  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [CNT_W-1:0]  issue_cnt_r;
   logic [CNT_W-1:0]  rx_cnt_r;
   logic [ADDR_W-1:0] base_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [DATA_W-1:0] wr_data_r;
   logic              target_r;
   logic              last_grant_r;
   logic              served_wr_r;
   logic              pick_d_s;
   logic              issuing_s;
   logic              rx_take_s;
   logic              rx_last_s;

   // Fill bookkeeping; a tie between misses goes to whoever was not served last.
   always_comb begin
      pick_d_s  = bus.d_miss & (~bus.i_miss | ~last_grant_r);
      issuing_s = (state_r == ST_FILL) && (issue_cnt_r < CNT_WORDS);
      rx_take_s = (state_r == ST_FILL) && bus.mem_valid && (rx_cnt_r < CNT_WORDS);
      rx_last_s = rx_take_s && (rx_cnt_r == CNT_LAST);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.d_wr) begin
               state_nxt_s = ST_WRITE;
            end else if (bus.i_miss || bus.d_miss) begin
               state_nxt_s = ST_FILL;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WRITE: state_nxt_s = ST_DONE;
         ST_FILL: begin
            if (rx_last_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_FILL;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Request capture in IDLE and burst counters in FILL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_cnt_r  <= '0;
         rx_cnt_r     <= '0;
         base_r       <= '0;
         wr_addr_r    <= '0;
         wr_data_r    <= '0;
         target_r     <= 1'b0;
         last_grant_r <= 1'b0;
         served_wr_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               issue_cnt_r <= '0;
               rx_cnt_r    <= '0;
               if (bus.d_wr) begin
                  served_wr_r <= 1'b1;
                  wr_addr_r   <= bus.d_wr_addr;
                  wr_data_r   <= bus.d_wr_data;
               end else if (bus.i_miss || bus.d_miss) begin
                  served_wr_r <= 1'b0;
                  target_r    <= pick_d_s;
                  base_r      <= (pick_d_s ? bus.d_miss_addr : bus.i_miss_addr) & BLK_MASK;
               end
            end
            ST_FILL: begin
               if (issuing_s) begin
                  issue_cnt_r <= issue_cnt_r + CNT_W'(1);
               end
               if (rx_take_s) begin
                  rx_cnt_r <= rx_cnt_r + CNT_W'(1);
               end
               if (rx_last_s) begin
                  last_grant_r <= target_r;
               end
            end
            default: begin
               issue_cnt_r <= issue_cnt_r;
            end
         endcase
      end
   end

   // Output decode; fill words pass straight through from the memory.
   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.i_done    = 1'b0;
      bus.d_done    = 1'b0;
      bus.wr_ack    = 1'b0;
      bus.busy      = (state_r != ST_IDLE);
      case (state_r)
         ST_WRITE: begin
            bus.mem_en    = 1'b1;
            bus.mem_wr    = 1'b1;
            bus.mem_addr  = wr_addr_r;
            bus.mem_wdata = wr_data_r;
         end
         ST_FILL: begin
            if (issuing_s) begin
               bus.mem_en   = 1'b1;
               bus.mem_addr = base_r | ADDR_W'({issue_cnt_r[WIDX_W-1:0], 1'b0});
            end else begin
               bus.mem_en = 1'b0;
            end
         end
         ST_DONE: begin
            if (served_wr_r) begin
               bus.wr_ack = 1'b1;
            end else if (target_r) begin
               bus.d_done = 1'b1;
            end else begin
               bus.i_done = 1'b1;
            end
         end
         default: begin
            bus.mem_en = 1'b0;
         end
      endcase
      if (rx_take_s) begin
         bus.fill_valid = 1'b1;
         bus.fill_data  = bus.mem_rdata;
         bus.fill_word  = rx_cnt_r[WIDX_W-1:0];
         bus.fill_to_d  = target_r;
      end else begin
         bus.fill_valid = 1'b0;
         bus.fill_data  = '0;
         bus.fill_word  = '0;
         bus.fill_to_d  = 1'b0;
      end
   end
endmodule
